// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial feeder for the sequence detectors.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per
// clock on Bit_Out, qualified by Bit_Valid. Back-to-back words stream with no
// idle slot, so patterns spanning word boundaries stay contiguous.
//
// Optional feature macro: SER_PARITY_EN
//   defined   -> each word is followed by one even-parity slot (state PAR).
//   undefined -> WIDTH slots per word, no PAR state, no parity register.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous, active-low reset
//   Din        parallel word to serialize
//   Din_Valid  Din holds a valid word
//   Din_Ready  block can accept a word this cycle (combinational)
//   Bit_Out    serial data bit
//   Bit_Valid  Bit_Out is meaningful this cycle
//   Last       final bit of the word (parity slot when enabled)
//   Busy       a word is in flight
//   CS         current FSM state (0 IDLE, 1 SHIFT, 2 PAR)
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_Valid,
    output logic             Din_Ready,
    output logic             Bit_Out,
    output logic             Bit_Valid,
    output logic             Last,
    output logic             Busy,
    output logic [1:0]       CS
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state, n_state;
    logic [WIDTH-1:0] sh, n_sh;
    logic [CNT_W-1:0] cnt, n_cnt;
    logic             accept;
    logic             word_end;
`ifdef SER_PARITY_EN
    logic             par, n_par;
`endif

    assign word_end = (cnt == LAST_CNT);
    assign accept   = Din_Valid && Din_Ready;
    assign CS       = state;

    // Ready: idle, or on the final bit slot of the current word
    always_comb begin
        Din_Ready = 1'b0;
        case (state)
            IDLE:    Din_Ready = 1'b1;
`ifdef SER_PARITY_EN
            PAR:     Din_Ready = 1'b1;
`else
            SHIFT:   Din_Ready = word_end;
`endif
            default: Din_Ready = 1'b0;
        endcase
    end

    // Next-state / datapath; the illegal code (and PAR when unused) falls to IDLE
    always_comb begin
        n_state = IDLE;
        n_sh    = sh;
        n_cnt   = '0;
`ifdef SER_PARITY_EN
        n_par   = par;
`endif
        case (state)
            IDLE: begin
                n_state = IDLE;
            end
            SHIFT: begin
                n_state = SHIFT;
                n_sh    = (MSB_FIRST != 0) ? {sh[WIDTH-2:0], 1'b0}
                                           : {1'b0, sh[WIDTH-1:1]};
                n_cnt   = cnt + CNT_W'(1);
                if (word_end) begin
                    n_cnt = '0;
`ifdef SER_PARITY_EN
                    n_state = PAR;
`else
                    n_state = IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                n_state = IDLE;
            end
`endif
            default: begin
                n_state = IDLE;
                n_sh    = '0;
            end
        endcase
        // A load overrides the shift/end-of-word decision for gapless streaming
        if (accept) begin
            n_state = SHIFT;
            n_sh    = Din;
            n_cnt   = '0;
`ifdef SER_PARITY_EN
            n_par   = ^Din;
`endif
        end
    end

    // State and registered outputs, decoded from the next-state values
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            Bit_Out   <= 1'b0;
            Bit_Valid <= 1'b0;
            Last      <= 1'b0;
            Busy      <= 1'b0;
`ifdef SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= n_state;
            sh        <= n_sh;
            cnt       <= n_cnt;
            Busy      <= (n_state != IDLE);
            Bit_Valid <= (n_state == SHIFT) || (n_state == PAR);
`ifdef SER_PARITY_EN
            par       <= n_par;
            Last      <= (n_state == PAR);
            Bit_Out   <= (n_state == PAR) ? n_par :
                         (n_state == SHIFT) ? ((MSB_FIRST != 0) ? n_sh[WIDTH-1] : n_sh[0]) :
                         1'b0;
`else
            Last      <= (n_state == SHIFT) && (n_cnt == LAST_CNT);
            Bit_Out   <= (n_state == SHIFT) ? ((MSB_FIRST != 0) ? n_sh[WIDTH-1] : n_sh[0]) :
                         1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: one MSB-first and one LSB-first
// instance sharing clock and reset. Expected bit streams are hand-derived.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       Clk;
    logic       Rst;
    logic [7:0] din_m, din_l;
    logic       dv_m, dv_l;
    logic       rdy_m, rdy_l;
    logic       bo_m, bo_l;
    logic       bv_m, bv_l;
    logic       last_m, last_l;
    logic       busy_m, busy_l;
    logic [1:0] cs_m, cs_l;

    int errors = 0;
    int checks = 0;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .Clk(Clk), .Rst(Rst), .Din(din_m), .Din_Valid(dv_m), .Din_Ready(rdy_m),
        .Bit_Out(bo_m), .Bit_Valid(bv_m), .Last(last_m), .Busy(busy_m), .CS(cs_m)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .Clk(Clk), .Rst(Rst), .Din(din_l), .Din_Valid(dv_l), .Din_Ready(rdy_l),
        .Bit_Out(bo_l), .Bit_Valid(bv_l), .Last(last_l), .Busy(busy_l), .CS(cs_l)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called #1 after the accept edge; walks all slots of word w on the MSB
    // instance and returns #1 after the edge that ends the word.
    task automatic check_word(input logic [7:0] w, input string tag);
        logic [7:0] wv;
        wv = w;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s bit%0d", tag, i),   32'(bo_m),   32'(wv[7-i]));
            chk($sformatf("%s valid%0d", tag, i), 32'(bv_m),   32'(1));
            chk($sformatf("%s last%0d", tag, i),  32'(last_m), 32'((i == 7) && !PAR_EN));
            chk($sformatf("%s rdy%0d", tag, i),   32'(rdy_m),  32'((i == 7) && !PAR_EN));
            chk($sformatf("%s cs%0d", tag, i),    32'(cs_m),   32'(1));
            chk($sformatf("%s busy%0d", tag, i),  32'(busy_m), 32'(1));
            tick();
        end
        if (PAR_EN) begin
            chk({tag, " parbit"},   32'(bo_m),   32'(^wv));
            chk({tag, " parvalid"}, 32'(bv_m),   32'(1));
            chk({tag, " parlast"},  32'(last_m), 32'(1));
            chk({tag, " parcs"},    32'(cs_m),   32'(2));
            chk({tag, " parrdy"},   32'(rdy_m),  32'(1));
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle valid"}, 32'(bv_m),   32'(0));
        chk({tag, " idle bit"},   32'(bo_m),   32'(0));
        chk({tag, " idle last"},  32'(last_m), 32'(0));
        chk({tag, " idle busy"},  32'(busy_m), 32'(0));
        chk({tag, " idle cs"},    32'(cs_m),   32'(0));
        chk({tag, " idle rdy"},   32'(rdy_m),  32'(1));
    endtask

    initial begin
        Rst   = 1'b0;
        din_m = 8'h00;
        din_l = 8'h00;
        dv_m  = 1'b0;
        dv_l  = 1'b0;
        #1;
        check_idle("reset");
        chk("reset lsb valid", 32'(bv_l),  32'(0));
        chk("reset lsb rdy",   32'(rdy_l), 32'(1));
        tick();
        tick();
        Rst = 1'b1;
        tick();
        check_idle("post-reset");

        // Single word A5
        din_m = 8'hA5;
        dv_m  = 1'b1;
        tick();
        dv_m  = 1'b0;
        check_word(8'hA5, "single");
        check_idle("single");

        // Back-to-back A5, 3C, 07 with valid held high; Din changes after each accept
        din_m = 8'hA5;
        dv_m  = 1'b1;
        tick();
        din_m = 8'h3C;
        check_word(8'hA5, "b2b w0");
        din_m = 8'h07;
        check_word(8'h3C, "b2b w1");
        dv_m  = 1'b0;
        din_m = 8'hFF;
        check_word(8'h07, "b2b w2");
        check_idle("b2b");

        // Hold-off: valid low for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("holdoff busy%0d", i),  32'(busy_m), 32'(0));
            chk($sformatf("holdoff valid%0d", i), 32'(bv_m),   32'(0));
        end

        // Din stability: word C3 in flight while Din changes to 5A
        din_m = 8'hC3;
        dv_m  = 1'b1;
        tick();
        dv_m  = 1'b0;
        din_m = 8'h5A;
        check_word(8'hC3, "stable");
        check_idle("stable");

        // Reset mid-word after 3 bits of FF
        din_m = 8'hFF;
        dv_m  = 1'b1;
        tick();
        dv_m  = 1'b0;
        chk("midrst bit0", 32'(bo_m), 32'(1));
        tick();
        tick();
        chk("midrst bit2", 32'(bo_m), 32'(1));
        #2;
        Rst = 1'b0;
        #1;
        check_idle("midrst");
        #3;
        Rst = 1'b1;
        din_m = 8'h81;
        dv_m  = 1'b1;
        tick();
        dv_m  = 1'b0;
        check_word(8'h81, "after-rst");
        check_idle("after-rst");

        // LSB-first: 01 emits 1 then seven 0s
        din_l = 8'h01;
        dv_l  = 1'b1;
        tick();
        dv_l  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb bit%0d", i),   32'(bo_l),   32'(i == 0));
            chk($sformatf("lsb valid%0d", i), 32'(bv_l),   32'(1));
            chk($sformatf("lsb last%0d", i),  32'(last_l), 32'((i == 7) && !PAR_EN));
            tick();
        end
        if (PAR_EN) begin
            chk("lsb parbit",  32'(bo_l),   32'(1));
            chk("lsb parlast", 32'(last_l), 32'(1));
            tick();
        end
        chk("lsb idle valid", 32'(bv_l),   32'(0));
        chk("lsb idle busy",  32'(busy_l), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
